hs4_sync_tx: RTL and testbench

Clocked transmitter for the core's 4-phase bundled-data channels. It accepts words from a synchronous valid/ready source and drives them onto an asynchronous req/ack channel, which the receiving asynchronous stage matches with its delay elements. Data is held stable for a programmable number of clock cycles before `o_req` rises, and held until the return-to-zero phase completes. The block sits at the boundary between the synchronous fetch/debug logic and the asynchronous RV32I pipeline.

---
 rtl/hs4_sync_tx_pkg.sv | 19 +
 rtl/hs4_sync_tx_ack_sync.sv | 23 ++
 rtl/hs4_sync_tx.sv | 148 ++++++++++++++
 tb/tb_hs4_sync_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_sync_tx_pkg.sv
// Shared definitions for the 4-phase bundled-data channel endpoints.
package hs4_sync_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StReqHi,
    StReqLo
  } hs4_state_t;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned SetupCntW = 4;

  // Width of a counter that must be able to hold the value t.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/hs4_sync_tx_ack_sync.sv
// Flop-chain synchronizer for the asynchronous acknowledge input.
module hs4_sync_tx_ack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_async};
    end
  end

  assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_sync_tx.sv
// Synchronous valid/ready source to asynchronous 4-phase bundled-data transmitter.
module hs4_sync_tx
  import hs4_sync_tx_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_req,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  output logic          o_busy,
  output logic          o_timeout,
  input  logic          i_clr_timeout
);

  localparam int unsigned WaitW = cnt_width(TIMEOUT);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [SetupCntW-1:0] SetupLoad = SetupCntW'(SETUP_CYC - 1);

  logic [DW-1:0] fifo_mem_q [FifoDepth];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          push, pop;
  logic          ack_s;

  hs4_state_t           state_q;
  logic [SetupCntW-1:0] setup_cnt_q;
  logic [WaitW-1:0]     wait_cnt_q;
  logic                 req_q;
  logic [DW-1:0]        data_q;
  logic                 timeout_q;
  logic                 waiting;
  logic                 tmo_set;

  hs4_sync_tx_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_ack),
    .o_sync  (ack_s)
  );

  assign o_ready = !i_rst && (count_q < 2'd2);
  assign push    = i_valid && o_ready;
  // A new word is only launched once the far end has returned to zero; this also
  // covers the first request after reset.
  assign pop     = (count_q != 2'd0) && !ack_s && ((state_q == StIdle) || (state_q == StReqLo));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign waiting = ((state_q == StReqHi) && !ack_s) || ((state_q == StReqLo) && ack_s);
  assign tmo_set = (TIMEOUT != 0) && waiting && (wait_cnt_q == WaitLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      req_q       <= 1'b0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (tmo_set) begin
        timeout_q <= 1'b1;
      end else if (i_clr_timeout) begin
        timeout_q <= 1'b0;
      end
      // Saturate so a cleared flag is not re-raised within the same long wait.
      if (waiting && (wait_cnt_q != WaitMax)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            data_q      <= fifo_mem_q[rd_ptr_q];
            setup_cnt_q <= SetupLoad;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          if (setup_cnt_q == '0) begin
            req_q      <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StReqHi;
          end else begin
            setup_cnt_q <= setup_cnt_q - 4'd1;
          end
        end
        StReqHi: begin
          if (ack_s) begin
            req_q      <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= StReqLo;
          end
        end
        StReqLo: begin
          if (!ack_s) begin
            if (pop) begin
              data_q      <= fifo_mem_q[rd_ptr_q];
              setup_cnt_q <= SetupLoad;
              state_q     <= StSetup;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_req     = req_q;
  assign o_data    = data_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != StIdle) || (count_q != 2'd0);

endmodule

// File: tb/tb_hs4_sync_tx.sv
// Randomized self-checking bench for hs4_sync_tx with a transaction-level reference model.
module tb_hs4_sync_tx;

  localparam int unsigned SC = 1;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 8;

  logic        clk;
  logic        i_rst, i_valid, o_ready, o_req, i_ack, o_busy, o_timeout, i_clr_timeout;
  logic [31:0] i_data, o_data;

  hs4_sync_tx #(
    .DW          (32),
    .SETUP_CYC   (SC),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .o_req         (o_req),
    .o_data        (o_data),
    .i_ack         (i_ack),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .i_clr_timeout (i_clr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus controls (written by the main process at posedge+2 only).
  bit auto_ack = 0, manual_ack = 0, rec = 0, rand_clr = 0, clr_manual = 0;
  int ack_dmax = 0;
  logic [31:0] sentq[$];
  logic [31:0] rxq[$];

  // Far end: returns ack after a random delay, logging each word it latches.
  int dly = 0;
  bit armed = 0;
  initial i_ack = 1'b0;
  always @(negedge clk) begin
    if (!auto_ack) begin
      i_ack = manual_ack;
      armed = 0;
    end else if (o_req !== i_ack) begin
      if (!armed) begin
        armed = 1;
        dly   = $urandom_range(ack_dmax, 0);
      end
      if (dly == 0) begin
        i_ack = o_req;
        armed = 0;
        if (o_req && rec) rxq.push_back(o_data);
      end else begin
        dly--;
      end
    end
  end

  initial i_clr_timeout = 1'b0;
  always @(negedge clk) i_clr_timeout = rand_clr ? ($urandom_range(7, 0) == 0) : clr_manual;

  // Reference model: word queue, a view of ack delayed by the synchronizer depth,
  // and the handshake rules expressed as remaining-setup / request-level / rtz-wait.
  logic [31:0] mq[$];
  bit          ah[SS];
  bit          m_inflight = 0, m_req = 0, m_to = 0;
  int          m_setup_left = 0, m_wait = 0;
  logic [31:0] m_data = 0;
  logic [31:0] prev_data = 0;
  logic        prev_req = 0;
  bit          was_rst = 0;

  initial foreach (ah[k]) ah[k] = 0;

  always @(posedge clk) begin
    bit seen, acc, tick, start;
    seen    = ah[SS-1];
    acc     = i_valid && !i_rst && (mq.size() < 2);
    was_rst = i_rst;
    if (i_rst) begin
      foreach (ah[k]) ah[k] = 0;
      mq.delete();
      m_inflight = 0; m_req = 0; m_to = 0; m_setup_left = 0; m_wait = 0; m_data = 0;
    end else begin
      for (int k = SS - 1; k > 0; k--) ah[k] = ah[k-1];
      ah[0] = i_ack;
      tick  = 0;
      start = 0;
      if (!m_inflight) begin
        start = (mq.size() != 0) && !seen;
      end else if (m_setup_left > 0) begin
        m_setup_left--;
        if (m_setup_left == 0) begin
          m_req  = 1;
          m_wait = 0;
        end
      end else if (m_req) begin
        if (seen) begin
          m_req  = 0;
          m_wait = 0;
        end else tick = 1;
      end else begin
        if (!seen) begin
          m_inflight = 0;
          start      = (mq.size() != 0);
        end else tick = 1;
      end
      if (start) begin
        m_data       = mq.pop_front();
        m_inflight   = 1;
        m_setup_left = SC;
      end
      if (tick) m_wait++;
      if (tick && TO != 0 && m_wait == TO) m_to = 1;
      else if (i_clr_timeout) m_to = 0;
      if (acc) mq.push_back(i_data);
    end
    #2;
    chk("req", o_req, m_req);
    chk("data", o_data, m_data);
    chk("timeout", o_timeout, m_to);
    chk("busy", o_busy, m_inflight || (mq.size() != 0));
    chk("ready", o_ready, !i_rst && (mq.size() < 2));
    if (prev_req === 1'b1 && !was_rst) chk("data_hold_under_req", o_data, prev_data);
    prev_data = o_data;
    prev_req  = o_req;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Returns just after the edge that accepts the word.
  task automatic push(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = w;
    while (o_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("push_ready_bound", o_ready, 1);
    end else begin
      @(posedge clk);
      if (rec) sentq.push_back(w);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_req(input logic v);
    int n = 0;
    while (o_req !== v && n < 200) begin
      step();
      n++;
    end
    chk("wait_req", o_req, v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    chk("wait_idle", o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", o_req, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_ready", o_ready, 0);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", o_ready, 1);

    // Single word, manual far end.
    push(32'hDEADBEEF);
    #2;
    chk("sw_busy", o_busy, 1);
    chk("sw_data_not_yet", o_data, 0);
    idle();
    step();
    chk("sw_data", o_data, 32'hDEADBEEF);
    chk("sw_req_lo", o_req, 0);
    step();
    chk("sw_req_rise", o_req, 1);
    step();
    step();
    manual_ack = 1;
    step();
    chk("sw_req_e0", o_req, 1);
    step();
    chk("sw_req_e1", o_req, 1);
    step();
    chk("sw_req_fall", o_req, 0);
    manual_ack = 0;
    wait_idle();
    chk("sw_data_final", o_data, 32'hDEADBEEF);

    // Back-to-back words with a quick far end.
    step();
    ack_dmax = 3;
    auto_ack = 1;
    rec      = 1;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    #2;
    chk("b2b_ready_full", o_ready, 0);
    idle();
    wait_idle();

    // Timeout with silent far end, then clear and late ack.
    step();
    rec      = 0;
    auto_ack = 0;
    push(32'hCAFE0001);
    idle();
    wait_req(1);
    repeat (7) step();
    chk("to_not_yet", o_timeout, 0);
    step();
    chk("to_set", o_timeout, 1);
    chk("to_req_held", o_req, 1);
    clr_manual = 1;
    step();
    step();
    chk("to_cleared", o_timeout, 0);
    clr_manual = 0;
    manual_ack = 1;
    wait_req(0);
    manual_ack = 0;
    wait_idle();
    chk("to_data", o_data, 32'hCAFE0001);
    chk("to_still_clear", o_timeout, 0);

    // Reset in the middle of a handshake with ack held high.
    push(32'h0000AAAA);
    push(32'h0000BBBB);
    idle();
    wait_req(1);
    manual_ack = 1;
    @(negedge clk);
    i_rst = 1'b1;
    step();
    chk("mr_req", o_req, 0);
    chk("mr_busy", o_busy, 0);
    chk("mr_data", o_data, 0);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("mr_ready", o_ready, 1);
    repeat (4) step();
    push(32'h0000CCCC);
    idle();
    repeat (6) step();
    chk("mr_hold_req", o_req, 0);
    chk("mr_hold_data", o_data, 0);
    chk("mr_hold_busy", o_busy, 1);
    manual_ack = 0;
    auto_ack   = 1;
    wait_idle();
    chk("mr_resume_data", o_data, 32'h0000CCCC);

    // Randomized traffic with jittered far end and random timeout clears.
    step();
    rec      = 1;
    ack_dmax = 20;
    rand_clr = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
      push($urandom);
    end
    idle();
    wait_idle();
    step();
    rand_clr = 0;

    chk("rx_count", rxq.size(), sentq.size());
    for (int i = 0; i < sentq.size() && i < rxq.size(); i++) chk("rx_word", rxq[i], sentq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
